spm_bus_if: RTL and testbench
=============================

# spm_bus_if

Per-stage memory access front end sitting directly upstream of the scratchpad memory port (one instance for IF, one for MEM). It decodes each word address from the pipeline stage. Scratchpad hits go straight to the dual-port RAM port with no wait states. Other addresses run a request/grant/ready transaction on the shared bus. It raises `busy` to stall the pipeline while a bus transfer is outstanding, and buffers returned data across pipeline stalls.

## Interface
Parameters:
- `WORD_W`, 32, data word width
- `ADDR_W`, 30, word address width from the stage
- `SPM_ADDR_W`, 12, scratchpad word address width (4096 words)
- `SPM_SEL`, 3'b011, value of `addr[ADDR_W-1:ADDR_W-3]` selecting the scratchpad

Ports:
- `clk` in 1: clock; one clock domain
- `reset_` in 1: reset, synchronous, active-low
- `stall` in 1: stage stall (high = hold)
- `flush` in 1: stage flush (high = suppress new access)
- `addr` in ADDR_W: word address
- `as_` in 1: address strobe, active-low
- `rw` in 1: 1 = read, 0 = write
- `wr_data` in WORD_W: write data
- `rd_data` out WORD_W: read data to stage
- `busy` out 1: access in progress; stage must stall
- `spm_addr` out SPM_ADDR_W: scratchpad address
- `spm_as_` out 1: scratchpad strobe, active-low
- `spm_rw` out 1: scratchpad read/write
- `spm_wr_data` out WORD_W: scratchpad write data
- `spm_rd_data` in WORD_W: scratchpad read data
- `bus_req_` out 1: bus request, active-low
- `bus_grnt_` in 1: bus grant, active-low
- `bus_addr` out ADDR_W: bus address
- `bus_as_` out 1: bus strobe, active-low
- `bus_rw` out 1: bus read/write
- `bus_wr_data` out WORD_W: bus write data
- `bus_rd_data` in WORD_W: bus read data
- `bus_rdy_` in 1: bus ready, active-low

## Operation
- `hit` = (`addr[ADDR_W-1:ADDR_W-3]` == `SPM_SEL`). `access` = !`as_` && !`flush`.
- Scratchpad signals are combinational and always driven.
  - `spm_addr` = `addr[SPM_ADDR_W-1:0]`, `spm_rw` = `rw`, `spm_wr_data` = `wr_data`.
  - `spm_as_` = 0 only when state is IDLE and `access` and `hit`.
- State machine:
  - IDLE, then `access && !hit`:
    - Register `bus_req_`=0 and latch `addr`/`rw`/`wr_data` into `bus_addr`/`bus_rw`/`bus_wr_data`.
    - Go to REQ.
  - IDLE, then `access && hit`: stay in IDLE. `busy`=0; this is a zero-wait access.
  - REQ: `busy`=1. When `bus_grnt_`=0, register `bus_as_`=0 for exactly one cycle and go to ACCESS. Otherwise hold.
  - ACCESS: `busy`=1 until `bus_rdy_`=0. On the `bus_rdy_`=0 cycle:
    - `busy`=0 and `rd_data`=`bus_rd_data` combinationally.
    - Capture `bus_rd_data` into `rd_buf` and register `bus_req_`=1.
    - Go to STALL if `stall`=1, else IDLE.
  - STALL: `busy`=0, `rd_data`=`rd_buf`. Return to IDLE when `stall`=0. No new access is started from STALL.
- `rd_data` mux:
  - IDLE with `hit`: `spm_rd_data`.
  - ACCESS with `bus_rdy_`=0: `bus_rd_data`.
  - All other cases: `rd_buf`.
- `flush` gates only new accesses. A bus transaction already in REQ/ACCESS runs to completion, because the bus cannot abort; the stage discards the result.
- `stall` in IDLE does not block access decode. The stage holds `as_`, so an access repeats harmlessly for reads. The stage must not re-issue a bus write.
- Writes: `bus_rd_data` is ignored for writes, but `rd_buf` still captures it.

## Timing
- Reset (`reset_`=0 at a rising edge):
  - state=IDLE, `bus_req_`=1, `bus_as_`=1, `bus_rw`=1, `bus_addr`=0, `bus_wr_data`=0, `rd_buf`=0.
  - `busy` evaluates to 0.
- Reset has priority over all transitions, including mid-REQ/ACCESS. Bus outputs release on the edge where reset is sampled.
- Scratchpad read: `spm_as_` is low in cycle N. The RAM returns data in cycle N+1 via its registered output, and `rd_data` reflects `spm_rd_data` whenever the state is IDLE and `hit`=1. The stage pipeline register accounts for this one cycle.
- Bus latency: 1 cycle to assert `bus_req_`, then grant wait, then 1 cycle of `bus_as_`, then ready wait. Minimum is 3 cycles from `as_` to `busy` falling.
- `busy` is combinational from state and `bus_rdy_`.

## Test plan
1. **Scratchpad read**
   - Stimulus: `addr`=30'h1800_0004, read, `as_`=0.
   - Required: `spm_as_`=0, `spm_addr`=12'h004, `busy`=0, `bus_req_` stays 1. `spm_rd_data`=32'hDEAD_BEEF next cycle appears on `rd_data`.
2. **Bus read with waits**
   - Stimulus: `addr`=30'h0000_0010, read; grant after 2 cycles, `bus_rdy_` after 3 more; `bus_rd_data`=32'h1234_5678.
   - Required: `bus_as_` low for one cycle with `bus_addr`=30'h10, `busy`=1 throughout, `rd_data`=32'h1234_5678 on the ready cycle, `bus_req_`=1 the next cycle.
3. **Bus write**
   - Stimulus: `rw`=0, `wr_data`=32'hA5A5_A5A5.
   - Required: `bus_rw`=0 and `bus_wr_data`=32'hA5A5_A5A5 while `bus_as_`=0.
4. **Stall across completion**
   - Stimulus: `stall`=1 on the ready cycle, held 4 cycles.
   - Required: state STALL, `rd_data` holds the captured word, `busy`=0, no second `bus_req_`. Return to IDLE one cycle after `stall`=0.
5. **Flush**
   - Stimulus: `flush`=1 with `as_`=0 in IDLE.
   - Required: `spm_as_`=1, `bus_req_`=1. `flush` asserted during ACCESS does not stop completion.
6. **Reset mid-ACCESS**
   - Stimulus: `reset_`=0 while waiting on `bus_rdy_`.
   - Required: next cycle `bus_req_`=1, `bus_as_`=1, `busy`=0, `rd_data`=0.

Source files
------------

// File: rtl/spm_bus_if_if.sv
// Shared-bus handshake bundle between a stage front end and the bus arbiter.
// All strobes are active-low; the master owns request/address/data-out.
interface spm_bus_if_if #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 30
);
    logic              bus_req_;
    logic              bus_grnt_;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_as_;
    logic              bus_rw;
    logic [WORD_W-1:0] bus_wr_data;
    logic [WORD_W-1:0] bus_rd_data;
    logic              bus_rdy_;

    modport master (
        output bus_req_,
        output bus_addr,
        output bus_as_,
        output bus_rw,
        output bus_wr_data,
        input  bus_grnt_,
        input  bus_rd_data,
        input  bus_rdy_
    );

    modport slave (
        input  bus_req_,
        input  bus_addr,
        input  bus_as_,
        input  bus_rw,
        input  bus_wr_data,
        output bus_grnt_,
        output bus_rd_data,
        output bus_rdy_
    );
endinterface

// File: rtl/spm_bus_if.sv
// Stage memory front end: zero-wait scratchpad hits, shared-bus misses
// with request/grant/ready handshake, busy stall and read-data buffering.
module spm_bus_if #(
    parameter int           WORD_W     = 32,
    parameter int           ADDR_W     = 30,
    parameter int           SPM_ADDR_W = 12,
    parameter logic [2:0]   SPM_SEL    = 3'b011
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  as_,
    input  logic                  rw,
    input  logic [WORD_W-1:0]     wr_data,
    output logic [WORD_W-1:0]     rd_data,
    output logic                  busy,
    output logic [SPM_ADDR_W-1:0] spm_addr,
    output logic                  spm_as_,
    output logic                  spm_rw,
    output logic [WORD_W-1:0]     spm_wr_data,
    input  logic [WORD_W-1:0]     spm_rd_data,
    spm_bus_if_if.master          bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_ACCESS,
        S_STALL
    } state_t;

    state_t              state_q;
    logic                req_q;
    logic                as_q;
    logic                rw_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WORD_W-1:0]   wd_q;
    logic [WORD_W-1:0]   rd_buf;

    logic hit;
    logic access;
    logic idle;
    logic rdy;

    assign hit    = (addr[ADDR_W-1 -: 3] == SPM_SEL);
    assign access = !as_ && !flush;
    assign idle   = (state_q == S_IDLE);
    assign rdy    = !bus.bus_rdy_;

    assign spm_addr    = addr[SPM_ADDR_W-1:0];
    assign spm_rw      = rw;
    assign spm_wr_data = wr_data;
    assign spm_as_     = !(idle && access && hit);

    assign bus.bus_req_    = req_q;
    assign bus.bus_as_     = as_q;
    assign bus.bus_rw      = rw_q;
    assign bus.bus_addr    = addr_q;
    assign bus.bus_wr_data = wd_q;

    assign busy = (state_q == S_REQ)
               || (state_q == S_ACCESS && !rdy);

    // Completing bus read bypasses rd_buf so the stage sees it unstalled.
    always_comb begin
        rd_data = rd_buf;
        if (idle && hit) begin
            rd_data = spm_rd_data;
        end else if (state_q == S_ACCESS && rdy) begin
            rd_data = bus.bus_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_q <= S_IDLE;
            req_q   <= 1'b1;
            as_q    <= 1'b1;
            rw_q    <= 1'b1;
            addr_q  <= '0;
            wd_q    <= '0;
            rd_buf  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (access && !hit) begin
                        req_q   <= 1'b0;
                        addr_q  <= addr;
                        rw_q    <= rw;
                        wd_q    <= wr_data;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (!bus.bus_grnt_) begin
                        as_q    <= 1'b0;
                        state_q <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // Strobe is a single-cycle pulse.
                    as_q <= 1'b1;
                    if (rdy) begin
                        rd_buf  <= bus.bus_rd_data;
                        req_q   <= 1'b1;
                        state_q <= stall ? S_STALL : S_IDLE;
                    end
                end
                S_STALL: begin
                    if (!stall) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spm_bus_if.sv
// Directed bench for spm_bus_if: per-cycle model comparison plus
// hand-computed literal checks for each scenario.
module tb_spm_bus_if;

    logic        clk = 1'b0;
    logic        reset_;
    logic        stall;
    logic        flush;
    logic [29:0] addr;
    logic        as_;
    logic        rw;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        busy;
    logic [11:0] spm_addr;
    logic        spm_as_;
    logic        spm_rw;
    logic [31:0] spm_wr_data;
    logic [31:0] spm_rd_data;

    int errors = 0;
    int checks = 0;
    bit en     = 1'b0;

    spm_bus_if_if #(.WORD_W(32), .ADDR_W(30)) bus_i ();

    spm_bus_if dut (
        .clk         (clk),
        .reset_      (reset_),
        .stall       (stall),
        .flush       (flush),
        .addr        (addr),
        .as_         (as_),
        .rw          (rw),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .busy        (busy),
        .spm_addr    (spm_addr),
        .spm_as_     (spm_as_),
        .spm_rw      (spm_rw),
        .spm_wr_data (spm_wr_data),
        .spm_rd_data (spm_rd_data),
        .bus         (bus_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Model: a bus transfer is "pending" from decode until ready;
    // "granted" once the arbiter answered; "hold" keeps the word for a stall.
    bit          pend = 0, granted = 0, hold = 0;
    logic        m_req = 1, m_as = 1, m_rw = 1;
    logic [29:0] m_addr = '0;
    logic [31:0] m_wd = '0, m_buf = '0;

    function automatic bit is_hit(input logic [29:0] a);
        return a[29:27] == 3'b011;
    endfunction

    always @(posedge clk) begin
        if (!reset_) begin
            pend = 0; granted = 0; hold = 0;
            m_req = 1; m_as = 1; m_rw = 1;
            m_addr = '0; m_wd = '0; m_buf = '0;
        end else if (hold) begin
            hold = stall;
        end else if (!pend) begin
            if (!as_ && !flush && !is_hit(addr)) begin
                pend = 1; m_req = 0;
                m_addr = addr; m_rw = rw; m_wd = wr_data;
            end
        end else if (!granted) begin
            if (!bus_i.bus_grnt_) begin
                granted = 1; m_as = 0;
            end
        end else begin
            m_as = 1;
            if (!bus_i.bus_rdy_) begin
                m_buf = bus_i.bus_rd_data;
                m_req = 1; pend = 0; granted = 0; hold = stall;
            end
        end
    end

    always @(negedge clk) begin
        if (en) begin
            bit free, done;
            logic [31:0] e_rd;
            free = !pend && !hold;
            done = pend && granted && !bus_i.bus_rdy_;
            e_rd = (free && is_hit(addr)) ? spm_rd_data :
                   done ? bus_i.bus_rd_data : m_buf;
            check("spm_addr", 32'(spm_addr), 32'(addr[11:0]));
            check("spm_rw", 32'(spm_rw), 32'(rw));
            check("spm_wr_data", spm_wr_data, wr_data);
            check("spm_as_", 32'(spm_as_),
                  32'(!(free && !as_ && !flush && is_hit(addr))));
            check("busy", 32'(busy), 32'(pend && !done));
            check("rd_data", rd_data, e_rd);
            check("bus_req_", 32'(bus_i.bus_req_), 32'(m_req));
            check("bus_as_", 32'(bus_i.bus_as_), 32'(m_as));
            check("bus_rw", 32'(bus_i.bus_rw), 32'(m_rw));
            check("bus_addr", 32'(bus_i.bus_addr), 32'(m_addr));
            check("bus_wr_data", bus_i.bus_wr_data, m_wd);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset_ = 0; stall = 0; flush = 0; addr = '0; as_ = 1;
        rw = 1; wr_data = '0; spm_rd_data = '0;
        bus_i.bus_grnt_ = 1; bus_i.bus_rdy_ = 1; bus_i.bus_rd_data = '0;
        en = 1;
        tick();
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req", 32'(bus_i.bus_req_), 32'd1);
        check("rst_rd", rd_data, 32'd0);
        reset_ = 1;
        tick();

        // Scratchpad read
        addr = 30'h1800_0004; rw = 1; as_ = 0;
        #1;
        check("spm_as_low", 32'(spm_as_), 32'd0);
        check("spm_addr4", 32'(spm_addr), 32'h004);
        check("spm_busy", 32'(busy), 32'd0);
        tick();
        spm_rd_data = 32'hDEAD_BEEF;
        #1;
        check("spm_rd", rd_data, 32'hDEAD_BEEF);
        check("spm_noreq", 32'(bus_i.bus_req_), 32'd1);
        tick();
        as_ = 1;

        // Bus read with 2-cycle grant wait, 3-cycle ready wait
        addr = 30'h10; as_ = 0;
        tick();
        as_ = 1;
        #1;
        check("rd_req", 32'(bus_i.bus_req_), 32'd0);
        check("rd_busy_req", 32'(busy), 32'd1);
        tick();
        bus_i.bus_grnt_ = 0;
        tick();
        bus_i.bus_grnt_ = 1;
        #1;
        check("rd_as", 32'(bus_i.bus_as_), 32'd0);
        check("rd_addr", 32'(bus_i.bus_addr), 32'h10);
        tick();
        #1;
        check("rd_as_pulse", 32'(bus_i.bus_as_), 32'd1);
        check("rd_busy_acc", 32'(busy), 32'd1);
        tick();
        bus_i.bus_rdy_ = 0; bus_i.bus_rd_data = 32'h1234_5678;
        #1;
        check("rd_data_rdy", rd_data, 32'h1234_5678);
        check("rd_busy_rdy", 32'(busy), 32'd0);
        tick();
        bus_i.bus_rdy_ = 1; bus_i.bus_rd_data = '0;
        #1;
        check("rd_req_rel", 32'(bus_i.bus_req_), 32'd1);
        check("rd_buf", rd_data, 32'h1234_5678);
        tick();

        // Bus write; stage changes its operands after decode
        addr = 30'h20; rw = 0; wr_data = 32'hA5A5_A5A5; as_ = 0;
        tick();
        as_ = 1; rw = 1; wr_data = '0; bus_i.bus_grnt_ = 0;
        tick();
        bus_i.bus_grnt_ = 1;
        #1;
        check("wr_as", 32'(bus_i.bus_as_), 32'd0);
        check("wr_rw", 32'(bus_i.bus_rw), 32'd0);
        check("wr_data", bus_i.bus_wr_data, 32'hA5A5_A5A5);
        bus_i.bus_rdy_ = 0; bus_i.bus_rd_data = 32'h0BAD_F00D;
        tick();
        bus_i.bus_rdy_ = 1; bus_i.bus_rd_data = '0;
        tick();

        // Stall across completion, miss presented while stalled
        addr = 30'h40; as_ = 0;
        tick();
        as_ = 1; bus_i.bus_grnt_ = 0;
        tick();
        bus_i.bus_grnt_ = 1;
        bus_i.bus_rdy_ = 0; bus_i.bus_rd_data = 32'hCAFE_F00D; stall = 1;
        #1;
        check("st_rdy_rd", rd_data, 32'hCAFE_F00D);
        tick();
        bus_i.bus_rdy_ = 1; bus_i.bus_rd_data = '0;
        addr = 30'h80; as_ = 0;
        #1;
        check("st_hold_rd", rd_data, 32'hCAFE_F00D);
        check("st_busy", 32'(busy), 32'd0);
        tick();
        tick();
        #1;
        check("st_noreq", 32'(bus_i.bus_req_), 32'd1);
        tick();
        stall = 0; as_ = 1;
        tick();
        #1;
        check("st_idle_rd", rd_data, 32'hCAFE_F00D);
        check("st_idle_req", 32'(bus_i.bus_req_), 32'd1);
        tick();

        // Flush suppresses new hit and miss accesses
        flush = 1; addr = 30'h1800_0008; as_ = 0;
        #1;
        check("fl_spm_as", 32'(spm_as_), 32'd1);
        tick();
        addr = 30'h100;
        tick();
        #1;
        check("fl_req", 32'(bus_i.bus_req_), 32'd1);
        flush = 0; as_ = 1;
        tick();

        // Flush during ACCESS does not abort the transfer
        addr = 30'h200; as_ = 0;
        tick();
        as_ = 1; bus_i.bus_grnt_ = 0;
        tick();
        bus_i.bus_grnt_ = 1; flush = 1;
        tick();
        bus_i.bus_rdy_ = 0; bus_i.bus_rd_data = 32'h0000_0077;
        #1;
        check("fl_done_busy", 32'(busy), 32'd0);
        check("fl_done_rd", rd_data, 32'h77);
        tick();
        bus_i.bus_rdy_ = 1; flush = 0; bus_i.bus_rd_data = '0;
        tick();

        // Reset while waiting for ready
        addr = 30'h300; as_ = 0;
        tick();
        as_ = 1; bus_i.bus_grnt_ = 0;
        tick();
        bus_i.bus_grnt_ = 1;
        tick();
        #1;
        check("rs_busy_pre", 32'(busy), 32'd1);
        reset_ = 0;
        tick();
        #1;
        check("rs_req", 32'(bus_i.bus_req_), 32'd1);
        check("rs_as", 32'(bus_i.bus_as_), 32'd1);
        check("rs_busy", 32'(busy), 32'd0);
        check("rs_rd", rd_data, 32'd0);
        reset_ = 1;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
